// File: rtl/vc_input_buffer_if.sv
// -----------------------------------------------------------------------------
// vc_input_buffer_if
//   Bundles the flit write port, the switch-side pop port and the status /
//   credit outputs of a two-VC router input buffer.
//
//   master : upstream link plus switch stage. Drives flit_in/flit_valid/flit_vc
//            and rd_en/rd_vc. Observes the popped flit, credits and flags.
//   slave  : the input buffer itself.
//
//   Signals
//     flit_in[FLIT_W]    incoming flit data
//     flit_valid         flit_in valid this cycle
//     flit_vc            target VC of flit_in
//     rd_en, rd_vc       pop request and the VC to pop
//     flit_out[FLIT_W]   popped flit (registered)
//     flit_out_valid     one-cycle pulse per pop
//     credit_out         one-cycle credit pulse to upstream
//     credit_vc          VC the credit belongs to
//     vc_empty[2]        per-VC empty flags
//     vc_full[2]         per-VC full flags
//     overflow_err       sticky write-to-full indication
//     init_busy          credit initialisation in progress
// -----------------------------------------------------------------------------
interface vc_input_buffer_if #(
  parameter int FLIT_W = 16
);
  logic [FLIT_W-1:0] flit_in;
  logic              flit_valid;
  logic              flit_vc;
  logic              rd_en;
  logic              rd_vc;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  logic              credit_out;
  logic              credit_vc;
  logic [1:0]        vc_empty;
  logic [1:0]        vc_full;
  logic              overflow_err;
  logic              init_busy;

  modport master (
    output flit_in, flit_valid, flit_vc, rd_en, rd_vc,
    input  flit_out, flit_out_valid, credit_out, credit_vc,
           vc_empty, vc_full, overflow_err, init_busy
  );

  modport slave (
    input  flit_in, flit_valid, flit_vc, rd_en, rd_vc,
    output flit_out, flit_out_valid, credit_out, credit_vc,
           vc_empty, vc_full, overflow_err, init_busy
  );
endinterface

// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
//   Router input buffer with two virtual channels. Each VC is a circular FIFO
//   of DEPTH flits. A pop returns the head flit one cycle later together with
//   a credit pulse for that VC. A write to a full VC is dropped and latches
//   overflow_err, unless the same VC is popped in the same cycle, in which
//   case the freed slot absorbs the write.
//
//   Parameters
//     FLIT_W  flit width in bits
//     DEPTH   entries per VC, power of two, >= 2
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    vc_input_buffer_if.slave (data, pop, credit and status signals)
//
//   Build option
//     VCBUF_CREDIT_INIT_EN  when defined, after reset the buffer issues
//                           2*DEPTH credits (DEPTH for VC0, then DEPTH for VC1)
//                           while init_busy=1; pops are ignored during that
//                           window. When undefined, init_busy is tied low and
//                           the upstream presets its credit counters to DEPTH.
// -----------------------------------------------------------------------------
module vc_input_buffer #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             rst_n,
  vc_input_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [FLIT_W-1:0] mem_q [2][DEPTH];

  ptr_t [1:0] wr_ptr_q, wr_ptr_d;
  ptr_t [1:0] rd_ptr_q, rd_ptr_d;
  cnt_t [1:0] cnt_q, cnt_d;

  logic [FLIT_W-1:0] flit_out_q;
  logic              flit_out_valid_q;
  logic              credit_out_q;
  logic              credit_vc_q;
  logic              overflow_q;
  logic              init_busy;

  logic [1:0] vc_empty;
  logic [1:0] vc_full;
  logic       pop_fire;
  logic       wr_fire;

  // Flags come straight from the registered counts.
  assign vc_empty[0] = (cnt_q[0] == '0);
  assign vc_empty[1] = (cnt_q[1] == '0);
  assign vc_full[0]  = (cnt_q[0] == cnt_t'(DEPTH));
  assign vc_full[1]  = (cnt_q[1] == cnt_t'(DEPTH));

  assign pop_fire = bus.rd_en && !vc_empty[bus.rd_vc] && !init_busy;
  // A full VC still accepts a write when the same VC is popped this cycle.
  assign wr_fire  = bus.flit_valid &&
                    (!vc_full[bus.flit_vc] || (pop_fire && (bus.rd_vc == bus.flit_vc)));

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      if (wr_fire && (bus.flit_vc == 1'(v))) begin
        wr_ptr_d[v] = wr_ptr_q[v] + ptr_t'(1);  // DEPTH is a power of two: wraps naturally
        cnt_d[v]    = cnt_d[v] + cnt_t'(1);
      end
      if (pop_fire && (bus.rd_vc == 1'(v))) begin
        rd_ptr_d[v] = rd_ptr_q[v] + ptr_t'(1);
        cnt_d[v]    = cnt_d[v] - cnt_t'(1);
      end
    end
  end

  // NOTE: the flit storage has no reset; pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      mem_q[bus.flit_vc][wr_ptr_q[bus.flit_vc]] <= bus.flit_in;
    end
  end

`ifdef VCBUF_CREDIT_INIT_EN
  logic init_busy_q;
  cnt_t init_cnt_q;   // counts 0 .. 2*DEPTH-1; MSB selects the VC
  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state is only ever assigned with <= so all registers update together.
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      flit_out_q       <= '0;
      flit_out_valid_q <= 1'b0;
      credit_out_q     <= 1'b0;
      credit_vc_q      <= 1'b0;
      overflow_q       <= 1'b0;
`ifdef VCBUF_CREDIT_INIT_EN
      init_busy_q      <= 1'b1;
      init_cnt_q       <= '0;
`endif
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      flit_out_valid_q <= pop_fire;
      credit_out_q     <= pop_fire;
      if (pop_fire) begin
        flit_out_q  <= mem_q[bus.rd_vc][rd_ptr_q[bus.rd_vc]];
        credit_vc_q <= bus.rd_vc;
      end
      if (bus.flit_valid && !wr_fire) begin
        overflow_q <= 1'b1;
      end
`ifdef VCBUF_CREDIT_INIT_EN
      // Pops are blocked while busy, so init credits never collide with pop credits.
      if (init_busy_q) begin
        credit_out_q <= 1'b1;
        credit_vc_q  <= init_cnt_q[PTR_W];
        init_cnt_q   <= init_cnt_q + cnt_t'(1);
        if (init_cnt_q == cnt_t'(2 * DEPTH - 1)) begin
          init_busy_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.flit_out       = flit_out_q;
  assign bus.flit_out_valid = flit_out_valid_q;
  assign bus.credit_out     = credit_out_q;
  assign bus.credit_vc      = credit_vc_q;
  assign bus.vc_empty       = vc_empty;
  assign bus.vc_full        = vc_full;
  assign bus.overflow_err   = overflow_q;
  assign bus.init_busy      = init_busy;

endmodule

// File: tb/tb_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_vc_input_buffer
//   Directed scenarios plus a randomized run of vc_input_buffer, compared
//   against a queue-based model of the two virtual channels.
//   Build with +define+VCBUF_CREDIT_INIT_EN to cover credit initialisation.
// -----------------------------------------------------------------------------
module tb_vc_input_buffer;

  localparam int FLIT_W = 16;
  localparam int DEPTH  = 4;
`ifdef VCBUF_CREDIT_INIT_EN
  localparam int INIT_CREDITS = 2 * DEPTH;
`else
  localparam int INIT_CREDITS = 0;
`endif

  logic clk;
  logic rst_n;

  vc_input_buffer_if #(.FLIT_W(FLIT_W)) bus ();

  vc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------- model
  logic [FLIT_W-1:0] q0[$];
  logic [FLIT_W-1:0] q1[$];
  logic [FLIT_W-1:0] m_out;
  logic              m_valid;
  logic              m_credit;
  logic              m_cvc;
  logic              m_ovf;
  int                m_left;   // initialisation credits still to be issued

  function automatic int qsize(input logic vc);
    return vc ? q1.size() : q0.size();
  endfunction

  function automatic logic [1:0] m_empty();
    return {q1.size() == 0, q0.size() == 0};
  endfunction

  function automatic logic [1:0] m_full();
    return {q1.size() == DEPTH, q0.size() == DEPTH};
  endfunction

  task automatic model_step(input logic fv, input logic [FLIT_W-1:0] f,
                            input logic fvc, input logic re, input logic rvc);
    logic busy;
    logic pop;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_out = '0; m_valid = 1'b0; m_credit = 1'b0; m_cvc = 1'b0;
      m_ovf = 1'b0; m_left = INIT_CREDITS;
    end else begin
      busy = (m_left > 0);
      pop  = re && (qsize(rvc) > 0) && !busy;
      m_valid  = pop;
      m_credit = pop;
      if (pop) begin
        if (rvc) m_out = q1.pop_front();
        else     m_out = q0.pop_front();
        m_cvc = rvc;
      end
      // The pop above already freed its slot, so a same-VC write into a full VC fits.
      if (fv) begin
        if (qsize(fvc) < DEPTH) begin
          if (fvc) q1.push_back(f);
          else     q0.push_back(f);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (busy) begin
        m_credit = 1'b1;
        m_cvc    = (m_left <= DEPTH);
        m_left--;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic fv, input logic [FLIT_W-1:0] f,
                       input logic fvc, input logic re, input logic rvc);
    bus.flit_valid = fv;
    bus.flit_in    = f;
    bus.flit_vc    = fvc;
    bus.rd_en      = re;
    bus.rd_vc      = rvc;
    model_step(fv, f, fvc, re, rvc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_init();
    for (int n = 0; n < 4 * DEPTH && m_left > 0; n++) idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b1, 16'($urandom), 1'($urandom), 1'b1, 1'($urandom));
    rst_n = 1'b1;
    wait_init();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    // Inputs toggling under reset must be ignored.
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 16'($urandom), 1'($urandom), 1'b1, 1'($urandom));
    checks++; if (bus.vc_empty !== 2'b11) begin errors++; $display("FAIL reset_empty got=%b exp=11", bus.vc_empty); end
    checks++; if (bus.vc_full !== 2'b00) begin errors++; $display("FAIL reset_full got=%b exp=00", bus.vc_full); end
    checks++; if (bus.flit_out !== 16'h0) begin errors++; $display("FAIL reset_flit_out got=%h exp=0000", bus.flit_out); end
    checks++; if (bus.flit_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.flit_out_valid); end
    checks++; if (bus.credit_out !== 1'b0 || bus.credit_vc !== 1'b0) begin errors++; $display("FAIL reset_credit got=%b/%b exp=0/0", bus.credit_out, bus.credit_vc); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow_err); end
    checks++; if (bus.init_busy !== (INIT_CREDITS > 0)) begin errors++; $display("FAIL reset_init_busy got=%b exp=%b", bus.init_busy, INIT_CREDITS > 0); end
    rst_n = 1'b1;
  endtask

`ifdef VCBUF_CREDIT_INIT_EN
  task automatic test_init();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      // First cycle writes a flit to VC0 (accepted); the rest try to pop it (ignored).
      if (i == 0) cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
      else        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.credit_out !== 1'b1 || bus.credit_vc !== (i >= DEPTH)) begin
        errors++; $display("FAIL init_credit i=%0d got=%b/%b exp=1/%b", i, bus.credit_out, bus.credit_vc, i >= DEPTH); end
      checks++; if (bus.flit_out_valid !== 1'b0) begin errors++; $display("FAIL init_pop_ignored i=%0d got=%b exp=0", i, bus.flit_out_valid); end
      checks++; if (bus.init_busy !== (i < 2 * DEPTH - 1)) begin errors++; $display("FAIL init_busy i=%0d got=%b exp=%b", i, bus.init_busy, i < 2 * DEPTH - 1); end
    end
    idle();
    checks++; if (bus.credit_out !== 1'b0 || bus.vc_empty !== 2'b10) begin
      errors++; $display("FAIL init_after got credit=%b empty=%b exp credit=0 empty=10", bus.credit_out, bus.vc_empty); end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.flit_out !== 16'h1234 || bus.flit_out_valid !== 1'b1 || bus.credit_out !== 1'b1 || bus.credit_vc !== 1'b0) begin
      errors++; $display("FAIL init_first_pop got=%h v=%b c=%b/%b exp=1234 v=1 c=1/0", bus.flit_out, bus.flit_out_valid, bus.credit_out, bus.credit_vc); end
  endtask
`endif

  task automatic test_in_order();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (bus.vc_full !== 2'b01 || bus.vc_empty !== 2'b10) begin
      errors++; $display("FAIL order_flags got full=%b empty=%b exp full=01 empty=10", bus.vc_full, bus.vc_empty); end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++; if (bus.flit_out !== 16'hA000 + 16'(i) || bus.flit_out_valid !== 1'b1) begin
        errors++; $display("FAIL order_pop%0d got=%h v=%b exp=%h v=1", i, bus.flit_out, bus.flit_out_valid, 16'hA000 + 16'(i)); end
      checks++; if (bus.credit_out !== 1'b1 || bus.credit_vc !== 1'b0) begin
        errors++; $display("FAIL order_credit%0d got=%b/%b exp=1/0", i, bus.credit_out, bus.credit_vc); end
    end
    idle();
    checks++; if (bus.flit_out_valid !== 1'b0 || bus.flit_out !== 16'hA004 || bus.credit_out !== 1'b0) begin
      errors++; $display("FAIL order_hold got=%h v=%b c=%b exp=a004 v=0 c=0", bus.flit_out, bus.flit_out_valid, bus.credit_out); end
    checks++; if (bus.vc_empty !== 2'b11) begin errors++; $display("FAIL order_empty got=%b exp=11", bus.vc_empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'hB100 + 16'(i), 1'b1, 1'b0, 1'b0);
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", bus.overflow_err); end
    cycle(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.vc_full !== 2'b10) begin errors++; $display("FAIL ovf_full got=%b exp=10", bus.vc_full); end
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.overflow_err); end
    // Drain VC1: the dropped 0xDEAD must not appear, and the flag stays sticky.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checks++; if (bus.flit_out !== 16'hB100 + 16'(i) || bus.overflow_err !== 1'b1) begin
        errors++; $display("FAIL ovf_drain%0d got=%h ovf=%b exp=%h ovf=1", i, bus.flit_out, bus.overflow_err, 16'hB100 + 16'(i)); end
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.flit_out_valid !== 1'b0 || bus.vc_empty !== 2'b11) begin
      errors++; $display("FAIL ovf_dropped got v=%b empty=%b exp v=0 empty=11", bus.flit_out_valid, bus.vc_empty); end
    do_reset();
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", bus.overflow_err); end
  endtask

  task automatic test_full_pass_through();
    logic [FLIT_W-1:0] fl [4];
    for (int i = 0; i < 4; i++) begin
      fl[i] = 16'($urandom);
      cycle(1'b1, fl[i], 1'b1, 1'b0, 1'b0);
    end
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.overflow_err !== 1'b0 || bus.vc_full !== 2'b10) begin
      errors++; $display("FAIL pass_accept got ovf=%b full=%b exp ovf=0 full=10", bus.overflow_err, bus.vc_full); end
    checks++; if (bus.flit_out !== fl[0] || bus.flit_out_valid !== 1'b1) begin
      errors++; $display("FAIL pass_head got=%h exp=%h", bus.flit_out, fl[0]); end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checks++; if (bus.flit_out !== ((i < 4) ? fl[i] : 16'hBEEF) || bus.credit_vc !== 1'b1) begin
        errors++; $display("FAIL pass_pop%0d got=%h cvc=%b exp=%h cvc=1", i, bus.flit_out, bus.credit_vc, (i < 4) ? fl[i] : 16'hBEEF); end
    end
  endtask

  task automatic test_empty_pop();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.flit_out_valid !== 1'b0 || bus.credit_out !== 1'b0) begin
      errors++; $display("FAIL empty_pop got v=%b c=%b exp 0/0", bus.flit_out_valid, bus.credit_out); end
    checks++; if (bus.vc_empty !== 2'b11) begin errors++; $display("FAIL empty_flags got=%b exp=11", bus.vc_empty); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 16'h5501, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h5502, 1'b0, 1'b0, 1'b0);
    do_reset();
    checks++; if (bus.vc_empty !== 2'b11) begin errors++; $display("FAIL rstmid_empty got=%b exp=11", bus.vc_empty); end
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.flit_out_valid !== 1'b0 || bus.credit_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_pop got v=%b c=%b exp 0/0", bus.flit_out_valid, bus.credit_out); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      cycle($urandom_range(0, 2) != 0, 16'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, 1'($urandom));
      checks++; if (bus.flit_out !== m_out) begin errors++; $display("FAIL rand_flit c=%0d got=%h exp=%h", c, bus.flit_out, m_out); end
      checks++; if (bus.flit_out_valid !== m_valid) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.flit_out_valid, m_valid); end
      checks++; if (bus.credit_out !== m_credit || bus.credit_vc !== m_cvc) begin
        errors++; $display("FAIL rand_credit c=%0d got=%b/%b exp=%b/%b", c, bus.credit_out, bus.credit_vc, m_credit, m_cvc); end
      checks++; if (bus.vc_empty !== m_empty() || bus.vc_full !== m_full()) begin
        errors++; $display("FAIL rand_flags c=%0d got e=%b f=%b exp e=%b f=%b", c, bus.vc_empty, bus.vc_full, m_empty(), m_full()); end
      checks++; if (bus.overflow_err !== m_ovf) begin errors++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, bus.overflow_err, m_ovf); end
      checks++; if (bus.init_busy !== (m_left > 0)) begin errors++; $display("FAIL rand_init c=%0d got=%b exp=%b", c, bus.init_busy, m_left > 0); end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.flit_in    = '0;
    bus.flit_valid = 1'b0;
    bus.flit_vc    = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_vc      = 1'b0;
    m_left         = INIT_CREDITS;

    test_reset();
`ifdef VCBUF_CREDIT_INIT_EN
    test_init();
`endif
    test_in_order();
    test_overflow();
    test_full_pass_through();
    test_empty_pop();
    test_reset_mid();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 Parameter FLIT_W, default 16, flit width in bits.
REQ-002 Parameter DEPTH, default 4, per-VC FIFO depth; power of 2, >= 2.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 flit_in  input  FLIT_W  incoming flit data.
REQ-006 flit_valid  input  1  flit_in is valid this cycle.
REQ-007 flit_vc  input  1  target VC (0/1) of flit_in.
REQ-008 rd_en  input  1  pop request from the switch stage.
REQ-009 rd_vc  input  1  VC to pop.
REQ-010 flit_out  output  FLIT_W  popped flit, registered.
REQ-011 flit_out_valid  output  1  flit_out valid, one-cycle pulse per pop.
REQ-012 credit_out  output  1  one-cycle credit return pulse to upstream.
REQ-013 credit_vc  output  1  VC the credit belongs to.
REQ-014 vc_empty  output  2  per-VC empty flags, bit n = VC n.
REQ-015 vc_full  output  2  per-VC full flags.
REQ-016 overflow_err  output  1  sticky: write attempted to a full VC.
REQ-017 init_busy  output  1  credit initialisation in progress.

Function
REQ-018 Two independent circular FIFOs (VC0, VC1), DEPTH entries each, with per-VC occupancy counters of width log2(DEPTH)+1.
REQ-019 Write: flit_valid=1 and VC flit_vc not full (pre-edge count) -> store flit_in at the write pointer; pointer wraps DEPTH-1 -> 0.
REQ-020 Write to a full VC with no same-cycle pop on that VC -> flit dropped, overflow_err set to 1 until reset.
REQ-021 Pop: rd_en=1, VC rd_vc non-empty, init_busy=0 -> next cycle flit_out = head of rd_vc, flit_out_valid=1, credit_out=1, credit_vc=rd_vc.
REQ-022 Pop latency is exactly 1 cycle; flit_out holds its last value when flit_out_valid=0.
REQ-023 Pop of an empty VC -> ignored: no flit_out_valid, no credit, no counter change.
REQ-024 Simultaneous write and pop on the same VC -> both performed, count unchanged; this holds even when the VC is full (the write is accepted, no overflow_err).
REQ-025 Simultaneous write to one VC and pop from the other -> independent; counts change by +1 and -1 respectively.
REQ-026 vc_empty[n]=(count_n==0) and vc_full[n]=(count_n==DEPTH), both derived from registered counts.
REQ-027 At most one credit pulse per cycle; credits map 1:1 to successful pops, except for the initialisation credits of REQ-032.

Reset
REQ-028 rst_n=0 at a rising edge -> pointers and counts 0, vc_empty=2'b11, vc_full=2'b00, flit_out=0, flit_out_valid=0, credit_out=0, credit_vc=0, overflow_err=0.
REQ-029 Reset mid-operation discards all stored flits; no credits are issued for discarded flits.
REQ-030 Flit_valid and rd_en are ignored in any cycle where rst_n=0.

Configuration
REQ-031 Macro VCBUF_CREDIT_INIT_EN selects credit initialisation.
REQ-032 Defined: after rst_n rises, init_busy=1 and credit_out pulses 2*DEPTH consecutive cycles, DEPTH with credit_vc=0 then DEPTH with credit_vc=1. Then init_busy=0. Pops are ignored while init_busy=1; writes are accepted.
REQ-033 Not defined: init_busy is tied to 0, no initialisation credits are issued, and the upstream presets its credit counters to DEPTH.

Verification
REQ-034 Write 4 flits 0xA001..0xA004 to VC0, pop VC0 x4 -> flit_out 0xA001..0xA004 in order, each 1 cycle after rd_en, with 4 credit pulses (credit_vc=0).
REQ-035 Fill VC1 with 4 flits, write a 5th with no pop -> vc_full=2'b10, 5th flit dropped, overflow_err=1 and held until reset.
REQ-036 VC1 full, write 0xBEEF to VC1 while popping VC1 -> no overflow_err, count stays 4, 0xBEEF emerges after 3 further pops.
REQ-037 Pop VC0 while empty -> flit_out_valid=0, credit_out=0, vc_empty=2'b11 unchanged.
REQ-038 Write 2 flits to VC0, assert rst_n=0 for 1 cycle, then pop VC0 -> vc_empty=2'b11, no flit_out_valid, no credit.
REQ-039 With VCBUF_CREDIT_INIT_EN defined, release reset -> 8 consecutive credit pulses (4x VC0, then 4x VC1), then init_busy=0; a pop issued during this window is ignored.
